// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side controller for the 8-bit combinational ALU.
// Accepts a command, holds registered operands on the ALU for a settle time,
// captures result and flags, and returns them over a response handshake.
// An accumulator holds the last captured result for chained operations.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op_code,
  input  logic [7:0] alu_out,
  input  logic       alu_carry_out,
  input  logic       alu_c_flag,
  input  logic       alu_zero_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_c_flag,
  output logic       rsp_zero_flag,
  output logic [2:0] rsp_op,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [7:0] acc;
  logic       accept;
  logic       capture;
  logic       done;

  // Only add and sub produce a meaningful carry from the ALU.
  function automatic logic mask_carry(input logic [2:0] op, input logic carry);
    return (op[2:1] == 2'b00) ? carry : 1'b0;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode; ready/valid depend on state only.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle counter: loaded on accept, counts down to the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       settle_cnt <= 4'd0;
    else if (accept)                               settle_cnt <= SETTLE_LOAD;
    else if (state == DRIVE && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
  end

  // ALU operand registers change only on command accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_op_code <= 3'b000;
    end else if (accept) begin
      alu_a       <= cmd_use_acc ? acc : cmd_a;
      alu_b       <= cmd_b;
      alu_op_code <= cmd_op;
    end
  end

  // Capture ALU result and flags into the response registers and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data      <= 8'h00;
      rsp_carry     <= 1'b0;
      rsp_c_flag    <= 1'b0;
      rsp_zero_flag <= 1'b0;
      rsp_op        <= 3'b000;
      acc           <= 8'h00;
    end else if (capture) begin
      rsp_data      <= alu_out;
      rsp_carry     <= mask_carry(alu_op_code, alu_carry_out);
      rsp_c_flag    <= alu_c_flag;
      rsp_zero_flag <= alu_zero_flag;
      rsp_op        <= alu_op_code;
      acc           <= alu_out;
    end
  end

  // Completed-response counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       op_count <= 8'h00;
    else if (done) op_count <= op_count + 8'h01;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table-driven directed vectors, backpressure and
// reset-in-flight sequences, and randomized ops against a reference model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (SETTLE_CYCLES = 1)
  logic       rst, cmd_valid, cmd_ready, cmd_use_acc, rsp_valid, rsp_ready;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_data, op_count;
  logic [2:0] cmd_op, alu_op_code, rsp_op;
  logic       alu_carry_out, alu_c_flag, alu_zero_flag;
  logic       rsp_carry, rsp_c_flag, rsp_zero_flag;
  logic       junk;

  // Second instance (SETTLE_CYCLES = 4)
  logic       q_rst, q_cmd_valid, q_cmd_ready, q_cmd_use_acc, q_rsp_valid, q_rsp_ready;
  logic [7:0] q_cmd_a, q_cmd_b, q_alu_a, q_alu_b, q_alu_out, q_rsp_data, q_op_count;
  logic [2:0] q_cmd_op, q_alu_op_code, q_rsp_op;
  logic       q_alu_carry_out, q_alu_c_flag, q_alu_zero_flag;
  logic       q_rsp_carry, q_rsp_c_flag, q_rsp_zero_flag;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_acc;
  logic [7:0] m_cnt;

  // Behavioural ALU: returns {out[7:0], carry, a>b, zero}. Carry for
  // non-arithmetic ops is an arbitrary value (junk) to exercise masking.
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic jc);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = jc;
    r = 8'h00;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a > b) ? 8'h01 : 8'h00;
      3'd6: r = {a[6:0], 1'b0};
      default: r = {b[6:0], 1'b0};
    endcase
    return {r, c, (a > b), (r == 8'h00)};
  endfunction

  assign {alu_out, alu_carry_out, alu_c_flag, alu_zero_flag} = alu_f(alu_a, alu_b, alu_op_code, junk);
  assign {q_alu_out, q_alu_carry_out, q_alu_c_flag, q_alu_zero_flag} = alu_f(q_alu_a, q_alu_b, q_alu_op_code, 1'b1);

  alu_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_c_flag(alu_c_flag),
    .alu_zero_flag(alu_zero_flag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_c_flag(rsp_c_flag),
    .rsp_zero_flag(rsp_zero_flag), .rsp_op(rsp_op), .op_count(op_count)
  );

  alu_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(q_rst), .cmd_valid(q_cmd_valid), .cmd_ready(q_cmd_ready),
    .cmd_a(q_cmd_a), .cmd_b(q_cmd_b), .cmd_op(q_cmd_op), .cmd_use_acc(q_cmd_use_acc),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_op_code(q_alu_op_code),
    .alu_out(q_alu_out), .alu_carry_out(q_alu_carry_out), .alu_c_flag(q_alu_c_flag),
    .alu_zero_flag(q_alu_zero_flag), .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready),
    .rsp_data(q_rsp_data), .rsp_carry(q_rsp_carry), .rsp_c_flag(q_rsp_c_flag),
    .rsp_zero_flag(q_rsp_zero_flag), .rsp_op(q_rsp_op), .op_count(q_op_count)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       use_acc;
    logic [7:0] exp_a;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_acc = 8'h00;
    m_cnt = 8'h00;
  endtask

  // Offer a command and return #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ua);
    int n;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Check driven operands, response latency, contents and count (rsp_ready = 1).
  task automatic complete(input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] op,
                          input logic [7:0] ed, input logic ec, input logic ecf, input logic ez);
    int lat;
    lat = 0;
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_op_code", 32'(alu_op_code), 32'(op));
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("rsp_latency", 32'(lat), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_carry", 32'(rsp_carry), 32'(ec));
    chk("rsp_c_flag", 32'(rsp_c_flag), 32'(ecf));
    chk("rsp_zero_flag", 32'(rsp_zero_flag), 32'(ez));
    chk("rsp_op", 32'(rsp_op), 32'(op));
    @(posedge clk); #1;
    m_cnt = m_cnt + 8'h01;
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  // Random command checked against the reference model.
  task automatic rand_op();
    logic [7:0]  a, b, a_eff;
    logic [2:0]  op;
    logic        ua;
    logic [10:0] r;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom);
    ua = 1'($urandom);
    junk = 1'($urandom);
    a_eff = ua ? m_acc : a;
    r = alu_f(a_eff, b, op, junk);
    send(a, b, op, ua);
    complete(a_eff, b, op, r[10:3], (op <= 3'd1) ? r[2] : 1'b0, r[1], r[0]);
    m_acc = r[10:3];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    vecs[0]  = '{8'hF0, 8'h20, 3'd0, 1'b0, 8'hF0, 8'h10, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{8'h05, 8'h05, 3'd1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'hFF, 8'hFF, 3'd2, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h0F, 8'h01, 3'd0, 1'b0, 8'h0F, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'hAA, 8'h01, 3'd3, 1'b1, 8'h10, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h3C, 8'h3C, 3'd4, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h03, 8'h07, 3'd5, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h81, 8'h00, 3'd6, 1'b0, 8'h81, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 8'h40, 3'd7, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h02, 8'h03, 3'd1, 1'b0, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'h02, 3'd0, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'd0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b1; junk = 1'b1;
    q_rst = 1'b1; q_cmd_valid = 1'b0; q_cmd_a = 8'h00; q_cmd_b = 8'h00; q_cmd_op = 3'd0;
    q_cmd_use_acc = 1'b0; q_rsp_ready = 1'b1;
    m_acc = 8'h00; m_cnt = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; q_rst = 1'b0;
    #1;

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op_code}), 32'd0);
    chk("rst_rsp", 32'({rsp_data, rsp_carry, rsp_c_flag, rsp_zero_flag, rsp_op}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);

    // Reset during the second DRIVE cycle (SETTLE_CYCLES = 4)
    q_cmd_a = 8'h0F; q_cmd_b = 8'h01; q_cmd_op = 3'd0; q_cmd_valid = 1'b1;
    @(posedge clk); #1;
    q_cmd_valid = 1'b0;
    chk("q_accept", 32'(q_cmd_ready), 32'd0);
    chk("q_alu_a", 32'(q_alu_a), 32'h0F);
    @(posedge clk); #1;
    chk("q_drive_no_valid", 32'(q_rsp_valid), 32'd0);
    q_rst = 1'b1;
    #1;
    chk("q_rst_alu", 32'({q_alu_a, q_alu_b, q_alu_op_code}), 32'd0);
    chk("q_rst_rsp", 32'({q_rsp_data, q_rsp_carry, q_rsp_c_flag, q_rsp_zero_flag, q_rsp_op}), 32'd0);
    chk("q_rst_valid", 32'(q_rsp_valid), 32'd0);
    @(negedge clk);
    q_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen = seen | q_rsp_valid;
    end
    chk("q_no_rsp_after_rst", 32'(seen), 32'd0);
    chk("q_cmd_ready_after", 32'(q_cmd_ready), 32'd1);
    chk("q_op_count", 32'(q_op_count), 32'd0);
    q_cmd_a = 8'h77; q_cmd_b = 8'h01; q_cmd_op = 3'd3; q_cmd_use_acc = 1'b1; q_cmd_valid = 1'b1;
    @(posedge clk); #1;
    q_cmd_valid = 1'b0;
    chk("q_acc_cleared", 32'(q_alu_a), 32'h00);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      junk = 1'b1;
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].use_acc);
      complete(vecs[i].exp_a, vecs[i].b, vecs[i].op, vecs[i].exp_data,
               vecs[i].exp_carry, vecs[i].exp_c, vecs[i].exp_z);
    end

    // Backpressure with a stalled command pending
    rsp_ready = 1'b0;
    send(8'h01, 8'h02, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_data0", 32'(rsp_data), 32'h03);
    cmd_a = 8'h22; cmd_b = 8'h11; cmd_op = 3'd4; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_data", 32'(rsp_data), 32'h03);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_count", 32'(op_count), 32'(m_cnt));
      chk("bp_alu_a_held", 32'(alu_a), 32'h01);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    m_cnt = m_cnt + 8'h01;
    chk("bp_release_count", 32'(op_count), 32'(m_cnt));
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_next_accepted", 32'(cmd_ready), 32'd0);
    complete(8'h22, 8'h11, 3'd4, 8'h33, 1'b0, 1'b1, 1'b0);

    // 256 randomized back-to-back ops from reset: count wraps to zero
    do_reset();
    #1;
    for (int i = 0; i < 256; i++) rand_op();
    chk("op_count_wrap", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
